// File: rtl/vedicmult_pipe.sv
// vedicmult_pipe - 3-stage pipelined Vedic multiplier with valid/ready streaming.
//
// Each WIDTH-bit operand is split into halves; stage 2 forms the four
// half-width Urdhva-Tiryagbhyam partial products, stage 3 sums them with
// CLA_BLOCK-grouped carry-lookahead adders. The whole pipe advances as one
// unit: adv = ~out_valid | out_ready, so an empty stage still waits behind
// a stalled output.
//
// Optional build macro: VEDIC_SIGNED_EN
//   defined   - a, b, prod are two's complement; stage 1 stores magnitudes
//               and the product sign, stage 3 negates the result.
//   undefined - unsigned only; no sign logic exists.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b valid
//   in_ready   out  operands accepted this cycle (equals adv)
//   a, b       in   WIDTH-bit operands
//   out_valid  out  prod valid
//   out_ready  in   consumer takes prod
//   prod       out  2*WIDTH-bit product
//   busy       out  any stage holds a valid operation
module vedicmult_pipe #(
   parameter int WIDTH     = 8,
   parameter int CLA_BLOCK = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 busy
);

   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH;

   // Urdhva-Tiryagbhyam: column k of the product is the sum of all cross
   // terms x[i]&y[j] with i+j==k plus the carry out of column k-1.
   function automatic logic [WIDTH-1:0] vedic_half(input logic [H-1:0] x,
                                                   input logic [H-1:0] y);
      logic [WIDTH-1:0] res;
      logic [WIDTH:0]   acc;
      logic [WIDTH:0]   carry;
      res   = '0;
      carry = '0;
      for (int k = 0; k < 2*H-1; k++) begin
         acc = carry;
         for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
               if (i + j == k)
                  acc = acc + {{WIDTH{1'b0}}, x[i] & y[j]};
            end
         end
         res[k] = acc[0];
         carry  = acc >> 1;
      end
      res[WIDTH-1] = carry[0];
      return res;
   endfunction

   // Carry-lookahead adder: each CLA_BLOCK group forms its group generate /
   // propagate so the block carry-out depends only on the block carry-in.
   function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y,
                                             input logic          cin);
      logic [PW-1:0] g;
      logic [PW-1:0] p;
      logic [PW:0]   c;
      logic          gg;
      logic          gp;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = cin;
      for (int blk = 0; blk < PW / CLA_BLOCK; blk++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int i = 0; i < CLA_BLOCK; i++) begin
            int idx;
            idx        = blk * CLA_BLOCK + i;
            c[idx+1]   = g[idx] | (p[idx] & c[idx]);
            gg         = g[idx] | (p[idx] & gg);
            gp         = gp & p[idx];
         end
         c[(blk+1)*CLA_BLOCK] = gg | (gp & c[blk*CLA_BLOCK]);
      end
      return p ^ c[PW-1:0];
   endfunction

   logic             adv;
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
   logic [WIDTH-1:0] ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
   logic [PW-1:0]    p3_q, p3_d;
   logic [PW-1:0]    mid_sum, part_sum, p_full;
`ifdef VEDIC_SIGNED_EN
   logic             s1_q, s1_d, s2_q, s2_d;
`endif

   assign adv       = ~v3_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = v3_q;
   assign prod      = p3_q;
   assign busy      = v1_q | v2_q | v3_q;

   // stage 1: operand capture
   always_comb begin
      v1_d = v1_q;
      a1_d = a1_q;
      b1_d = b1_q;
`ifdef VEDIC_SIGNED_EN
      s1_d = s1_q;
`endif
      if (adv) begin
         v1_d = in_valid;
`ifdef VEDIC_SIGNED_EN
         // -2^(WIDTH-1) negates to itself, which read unsigned is the exact magnitude
         a1_d = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
         b1_d = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
         s1_d = a[WIDTH-1] ^ b[WIDTH-1];
`else
         a1_d = a;
         b1_d = b;
`endif
      end
   end

   // stage 2: half-width partial products
   always_comb begin
      v2_d = v2_q;
      ll_d = ll_q;
      lh_d = lh_q;
      hl_d = hl_q;
      hh_d = hh_q;
`ifdef VEDIC_SIGNED_EN
      s2_d = s2_q;
`endif
      if (adv) begin
         v2_d = v1_q;
         ll_d = vedic_half(a1_q[H-1:0],     b1_q[H-1:0]);
         lh_d = vedic_half(a1_q[H-1:0],     b1_q[WIDTH-1:H]);
         hl_d = vedic_half(a1_q[WIDTH-1:H], b1_q[H-1:0]);
         hh_d = vedic_half(a1_q[WIDTH-1:H], b1_q[WIDTH-1:H]);
`ifdef VEDIC_SIGNED_EN
         s2_d = s1_q;
`endif
      end
   end

   // stage 3: P = LL + ((LH+HL) << H) + (HH << WIDTH), all at full product width
   always_comb begin
      mid_sum  = cla_add({{WIDTH{1'b0}}, lh_q}, {{WIDTH{1'b0}}, hl_q}, 1'b0);
      part_sum = cla_add({{WIDTH{1'b0}}, ll_q}, mid_sum << H, 1'b0);
      p_full   = cla_add(part_sum, {hh_q, {WIDTH{1'b0}}}, 1'b0);
`ifdef VEDIC_SIGNED_EN
      if (s2_q)
         p_full = cla_add(~p_full, '0, 1'b1);
`endif
      v3_d = v3_q;
      p3_d = p3_q;
      if (adv) begin
         v3_d = v2_q;
         p3_d = p_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         a1_q <= '0;
         b1_q <= '0;
         ll_q <= '0;
         lh_q <= '0;
         hl_q <= '0;
         hh_q <= '0;
         p3_q <= '0;
`ifdef VEDIC_SIGNED_EN
         s1_q <= 1'b0;
         s2_q <= 1'b0;
`endif
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         a1_q <= a1_d;
         b1_q <= b1_d;
         ll_q <= ll_d;
         lh_q <= lh_d;
         hl_q <= hl_d;
         hh_q <= hh_d;
         p3_q <= p3_d;
`ifdef VEDIC_SIGNED_EN
         s1_q <= s1_d;
         s2_q <= s2_d;
`endif
      end
   end

endmodule

// File: tb/tb_vedicmult_pipe.sv
module tb_vedicmult_pipe;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]    a, b;
   logic [2*W-1:0]  prod;

   logic            in_valid16, in_ready16, out_valid16, busy16;
   logic [15:0]     a16, b16;
   logic [31:0]     prod16;

   always #5 clk = ~clk;

   vedicmult_pipe #(.WIDTH(W), .CLA_BLOCK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .prod(prod), .busy(busy));

   vedicmult_pipe #(.WIDTH(16), .CLA_BLOCK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(1'b1),
      .prod(prod16), .busy(busy16));

   typedef struct {
      logic [15:0] exp;
      int          acc_cyc;
      bit          chk_lat;
   } sb_t;

   sb_t         sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [15:0] exp_in;
   bit          lat_in;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_SIGNED_EN
      logic signed [15:0] r;
      r = $signed(x) * $signed(y);
      return r;
`else
      return {8'd0, x} * {8'd0, y};
`endif
   endfunction

   always @(posedge clk) cyc++;

   // monitor: pops and compares on every delivery, pushes on every accept
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result prod=%0d expected=none", prod);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               chk("prod", prod, e.exp);
               if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 3);
            end
         end else if (out_valid && !out_ready && sb_q.size() > 0) begin
            chk("held_prod", prod, sb_q[0].exp);
            chk("stall_in_ready", in_ready, 1'b0);
         end
         if (in_valid && in_ready)
            sb_q.push_back('{exp: exp_in, acc_cyc: cyc, chk_lat: lat_in});
      end
   end

   // hold one pair until accepted; returns 1 ns after the accepting edge
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e, input bit lat);
      int guard;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      exp_in   = e;
      lat_in   = lat;
      guard    = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("send_timeout", 1, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_left", sb_q.size(), 0);
   endtask

   task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic [31:0] e);
      int n;
      @(posedge clk);
      #1;
      in_valid16 = 1'b1;
      a16 = x;
      b16 = y;
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid16 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("w16_seen", out_valid16, 1'b1);
      chk("w16_prod", prod16, e);
   endtask

   logic [7:0]  t1_a[4], t1_b[4], t2_a[4], t2_b[4];
   logic [15:0] t1_p[4], t2_p[4];

   initial begin
`ifdef VEDIC_SIGNED_EN
      t1_a = '{8'd251, 8'd128, 8'd127, 8'd19};
      t1_b = '{8'd8,   8'd128, 8'd255, 8'd20};
      t1_p = '{16'd65496, 16'd16384, 16'd65409, 16'd380};
      t2_a = '{8'd0,   8'd1,   8'd255, 8'd128};
      t2_b = '{8'd255, 8'd255, 8'd255, 8'd127};
      t2_p = '{16'd0, 16'd65535, 16'd1, 16'd49280};
`else
      t1_a = '{8'd5,  8'd15, 8'd25, 8'd19};
      t1_b = '{8'd8,  8'd15, 8'd27, 8'd20};
      t1_p = '{16'd40, 16'd225, 16'd675, 16'd380};
      t2_a = '{8'd0,   8'd1,   8'd255, 8'd128};
      t2_b = '{8'd255, 8'd255, 8'd255, 8'd2};
      t2_p = '{16'd0, 16'd255, 16'd65025, 16'd256};
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      exp_in     = '0;
      lat_in     = 1'b0;
      in_valid16 = 1'b0;
      a16        = '0;
      b16        = '0;
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_prod", prod, 16'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back with latency check
      for (int i = 0; i < 4; i++) send(t1_a[i], t1_b[i], t1_p[i], 1'b1);
      drain(20);

      // corners
      for (int i = 0; i < 4; i++) send(t2_a[i], t2_b[i], t2_p[i], 1'b1);
      drain(20);

      // backpressure
      out_ready = 1'b0;
      send(8'd100, 8'd100, 16'd10000, 1'b0);
      send(8'd17,  8'd3,   16'd51,    1'b0);
      send(8'd99,  8'd99,  16'd9801,  1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_queue", sb_q.size(), 3);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain(20);

      // asynchronous reset with two operations in flight
      send(8'd12, 8'd12, 16'd144, 1'b0);
      send(8'd7,  8'd9,  16'd63,  1'b0);
      #1;
      chk("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_prod", prod, 16'd0);
      chk("arst_in_ready", in_ready, 1'b1);
      sb_q.delete();
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_out_valid", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      // random traffic with random stalls
      for (int i = 0; i < 300; i++) begin
         logic [7:0] ra, rb;
         ra        = 8'($urandom_range(0, 255));
         rb        = 8'($urandom_range(0, 255));
         a         = ra;
         b         = rb;
         exp_in    = model(ra, rb);
         lat_in    = 1'b0;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(40);

      // 16-bit instance
`ifdef VEDIC_SIGNED_EN
      run16(16'hFFFF, 16'hFFFF, 32'd1);
      run16(16'h8000, 16'h8000, 32'd1073741824);
      run16(16'h7FFF, 16'hFFFF, 32'd4294934529);
`else
      run16(16'hFFFF, 16'hFFFF, 32'd4294836225);
      run16(16'd40000, 16'd3,   32'd120000);
      run16(16'd256,   16'd256, 32'd65536);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
